window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/video_pkg.sv | 15 +
 rtl/line_buffer_ram.sv | 24 ++
 rtl/window_3x3_gen.sv | 141 ++++++++++++++
 tb/tb_window_3x3_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants: default pixel width and the 3x3 window layout.
// Window element (r,c) sits at tap index 3*r+c; row 0 is the oldest line, column 0 the oldest pixel.
package video_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int WIN_DIM    = 3;
    localparam int WIN_TAPS   = WIN_DIM * WIN_DIM;
    localparam int WIN_CENTRE = 4;
    localparam int WIN_W_DEF  = WIN_TAPS * PIX_W_DEF;

    function automatic int win_idx(input int r, input int c);
        return (WIN_DIM * r) + c;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One-line pixel store: single registered write port, asynchronous read on the same address.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage write; contents are never reset, downstream gating hides stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator over a raster stream, emitting one window per interior pixel
// one clock after the pixel that completes it, plus a sticky line-length error flag.
module window_3x3_gen
    import video_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fval,
    input  logic                        lval,
    input  logic                        dval,
    input  logic [PIX_W-1:0]            pix,
    output logic [WIN_TAPS*PIX_W-1:0]   win,
    output logic                        win_valid,
    output logic [$clog2(WIDTH)-1:0]    win_col,
    output logic [$clog2(HEIGHT)-1:0]   win_row,
    output logic                        line_err
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int RW  = $clog2(HEIGHT + 1);
    localparam int AW  = $clog2(WIDTH);
    localparam int OCW = $clog2(WIDTH);
    localparam int ORW = $clog2(HEIGHT);

    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [RW-1:0] HEIGHT_C = RW'(HEIGHT);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic          fval_d_r, lval_d_r, armed_r, frame_act_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    logic          fval_start_s, frame_act_s, lval_rise_s, lval_fall_s;
    logic          acc_s, in_range_s, wr_s, win_hit_s, err_s;
    logic [CW-1:0] col_s, col_nxt_s, col_m1_s;
    logic [RW-1:0] row_s, row_nxt_s, row_m1_s;
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;

    // Frame/line qualification, position of the current pixel and next counter values.
    // armed_r ensures a frame only starts on a genuine fval rise seen after reset.
    always_comb begin
        fval_start_s = fval & ~fval_d_r & armed_r;
        frame_act_s  = fval & (fval_start_s | frame_act_r);
        lval_rise_s  = lval & ~lval_d_r;
        lval_fall_s  = ~lval & lval_d_r;
        acc_s        = frame_act_s & lval & dval;
        col_s        = lval_rise_s ? {CW{1'b0}} : col_r;
        row_s        = fval_start_s ? {RW{1'b0}} : row_r;
        in_range_s   = (col_s < WIDTH_C) && (row_s < HEIGHT_C);
        wr_s         = acc_s & in_range_s;
        win_hit_s    = wr_s && (col_s >= COL_TWO) && (row_s >= ROW_TWO);
        err_s        = (acc_s & ~in_range_s) |
                       (lval_fall_s & frame_act_s & (col_r != WIDTH_C));
        col_m1_s     = col_s - COL_ONE;
        row_m1_s     = row_s - ROW_ONE;

        if (!frame_act_s) begin
            col_nxt_s = {CW{1'b0}};
        end else if (acc_s && (col_s < WIDTH_C)) begin
            col_nxt_s = col_s + COL_ONE;
        end else begin
            col_nxt_s = col_s;
        end

        if (!frame_act_s) begin
            row_nxt_s = {RW{1'b0}};
        end else if (lval_fall_s && (row_s < HEIGHT_C)) begin
            row_nxt_s = row_s + ROW_ONE;
        end else begin
            row_nxt_s = row_s;
        end
    end

    // Edge detectors, position counters, sticky error and window strobe/coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            fval_d_r    <= 1'b0;
            lval_d_r    <= 1'b0;
            armed_r     <= 1'b0;
            frame_act_r <= 1'b0;
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            win_valid   <= 1'b0;
            win_col     <= {OCW{1'b0}};
            win_row     <= {ORW{1'b0}};
            line_err    <= 1'b0;
        end else begin
            fval_d_r    <= fval;
            lval_d_r    <= lval;
            armed_r     <= armed_r | ~fval;
            frame_act_r <= frame_act_s;
            col_r       <= col_nxt_s;
            row_r       <= row_nxt_s;
            win_valid   <= win_hit_s;
            line_err    <= line_err | err_s;
            if (win_hit_s) begin
                win_col <= col_m1_s[OCW-1:0];
                win_row <= row_m1_s[ORW-1:0];
            end
        end
    end

    // Column shift register: older columns move toward c=0, the new column enters at c=2.
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= {(WIN_TAPS*PIX_W){1'b0}};
        end else if (wr_s) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win[win_idx(r, 0)*PIX_W +: PIX_W] <= win[win_idx(r, 1)*PIX_W +: PIX_W];
                win[win_idx(r, 1)*PIX_W +: PIX_W] <= win[win_idx(r, 2)*PIX_W +: PIX_W];
            end
            win[win_idx(0, 2)*PIX_W +: PIX_W] <= lb1_rd_s;
            win[win_idx(1, 2)*PIX_W +: PIX_W] <= lb0_rd_s;
            win[win_idx(2, 2)*PIX_W +: PIX_W] <= pix;
        end
    end

    line_buffer_ram #(.DEPTH(WIDTH), .DW(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (wr_s),
        .addr  (col_s[AW-1:0]),
        .wdata (pix),
        .rdata (lb0_rd_s)
    );

    line_buffer_ram #(.DEPTH(WIDTH), .DW(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (wr_s),
        .addr  (col_s[AW-1:0]),
        .wdata (lb0_rd_s),
        .rdata (lb1_rd_s)
    );

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on an 8x6 raster with pix = (row<<4)|col (+ frame offset).
module tb_window_3x3_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst, fval, lval, dval;
    logic [7:0]  pix;
    logic [71:0] win;
    logic        win_valid;
    logic [2:0]  win_col, win_row;
    logic        line_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_win;
    int          g_content_max;
    bit          g_en, exp_err, first_seen;
    logic [7:0]  g_off, last_centre;
    logic [71:0] first_win;
    logic [2:0]  first_col, first_row;

    always #5 clk = ~clk;

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fval      (fval),
        .lval      (lval),
        .dval      (dval),
        .pix       (pix),
        .win       (win),
        .win_valid (win_valid),
        .win_col   (win_col),
        .win_row   (win_row),
        .line_err  (line_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int row, input int col, input logic [7:0] off);
        logic [71:0] w;
        logic [7:0]  v;
        w = 72'h0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v = 8'(((row - 2 + r) * 16) + (col - 2 + c)) + off;
                w[(3*r + c)*8 +: 8] = v;
            end
        end
        return w;
    endfunction

    task automatic pix_cycle(input int row, input int col, input bit dv);
        bit ev;
        lval = 1'b1;
        dval = dv;
        pix  = dv ? (8'((row * 16) + col) + g_off) : 8'h5A;
        tick();
        ev = g_en && dv && (row >= 2) && (col >= 2) && (row < H) && (col < W);
        chk("win_valid", {71'h0, win_valid}, {71'h0, ev});
        if (win_valid) begin
            n_win++;
            last_centre = win[39:32];
            if (!first_seen) begin
                first_seen = 1'b1;
                first_win  = win;
                first_col  = win_col;
                first_row  = win_row;
            end
        end
        if (ev && win_valid) begin
            chk("win_col", {69'h0, win_col}, 72'(col - 1));
            chk("win_row", {69'h0, win_row}, 72'(row - 1));
            if (row <= g_content_max) begin
                chk("win", win, exp_win(row, col, g_off));
            end
        end
    endtask

    task automatic send_line(input int row, input int npix, input int gap);
        for (int c = 0; c < npix; c++) begin
            pix_cycle(row, c, 1'b1);
            if (c < npix - 1) begin
                for (int g = 0; g < gap; g++) begin
                    pix_cycle(row, c, 1'b0);
                end
            end
        end
        if (npix != W && g_en) begin
            exp_err = 1'b1;
        end
        lval = 1'b0;
        dval = 1'b1;
        pix  = 8'hFF;
        tick();
        chk("idle_valid", {71'h0, win_valid}, 72'h0);
        chk("line_err", {71'h0, line_err}, {71'h0, exp_err});
        dval = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] off, input int gap, input int short_row, input int long_row);
        int npix;
        g_off         = off;
        g_content_max = (short_row >= 0) ? short_row : 99;
        fval = 1'b1;
        lval = 1'b0;
        dval = 1'b0;
        tick();
        for (int r = 0; r < H; r++) begin
            npix = (r == short_row) ? 7 : ((r == long_row) ? 9 : 8);
            send_line(r, npix, gap);
        end
        fval = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix = 8'h00;
        g_en = 1'b1; exp_err = 1'b0; g_off = 8'h00; g_content_max = 99;
        n_win = 0; first_seen = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", {71'h0, win_valid}, 72'h0);
        chk("rst_win", win, 72'h0);
        chk("rst_col", {69'h0, win_col}, 72'h0);
        chk("rst_row", {69'h0, win_row}, 72'h0);
        chk("rst_err", {71'h0, line_err}, 72'h0);
        rst = 1'b0;
        tick(); tick();

        // Plain full frame.
        n_win = 0; first_seen = 1'b0;
        send_frame(8'h00, 0, -1, -1);
        chk("full_count", 72'(n_win), 72'd24);
        chk("first_win", first_win, 72'h22_21_20_12_11_10_02_01_00);
        chk("first_col", {69'h0, first_col}, 72'd1);
        chk("first_row", {69'h0, first_row}, 72'd1);
        chk("last_centre", {64'h0, last_centre}, 72'h46);
        chk("full_err", {71'h0, line_err}, 72'h0);

        // dval gaps of three cycles between every pixel.
        n_win = 0;
        send_frame(8'h00, 3, -1, -1);
        chk("gap_count", 72'(n_win), 72'd24);
        chk("gap_last_centre", {64'h0, last_centre}, 72'h46);

        // Line 3 short by one pixel: row 3 yields only five windows.
        n_win = 0;
        send_frame(8'h00, 0, 3, -1);
        chk("short_count", 72'(n_win), 72'd23);
        chk("short_err", {71'h0, line_err}, 72'h1);

        // Line 1 long by one pixel: the extra pixel is dropped without touching the buffers.
        n_win = 0;
        send_frame(8'h00, 0, -1, 1);
        chk("long_count", 72'(n_win), 72'd24);
        chk("long_err", {71'h0, line_err}, 72'h1);

        // Reset during row 3, remainder of that frame must be ignored.
        g_off = 8'h00; g_content_max = 99;
        fval = 1'b1; tick();
        for (int r = 0; r < 3; r++) send_line(r, 8, 0);
        for (int c = 0; c < 4; c++) pix_cycle(3, c, 1'b1);
        rst = 1'b1; dval = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("mid_rst_valid", {71'h0, win_valid}, 72'h0);
        chk("mid_rst_win", win, 72'h0);
        chk("mid_rst_col", {69'h0, win_col}, 72'h0);
        chk("mid_rst_row", {69'h0, win_row}, 72'h0);
        chk("mid_rst_err", {71'h0, line_err}, 72'h0);
        exp_err = 1'b0; g_en = 1'b0; n_win = 0;
        for (int c = 4; c < 8; c++) pix_cycle(3, c, 1'b1);
        lval = 1'b0; tick(); tick();
        for (int r = 4; r < H; r++) send_line(r, 8, 0);
        fval = 1'b0; tick(); tick();
        chk("after_rst_silent", 72'(n_win), 72'd0);
        g_en = 1'b1; n_win = 0;
        send_frame(8'h00, 0, -1, -1);
        chk("post_rst_count", 72'(n_win), 72'd24);
        chk("post_rst_err", {71'h0, line_err}, 72'h0);

        // Back-to-back frames, second offset by 0x80.
        n_win = 0;
        send_frame(8'h00, 0, -1, -1);
        first_seen = 1'b0;
        send_frame(8'h80, 0, -1, -1);
        chk("b2b_count", 72'(n_win), 72'd48);
        chk("f2_first_win", first_win, 72'hA2_A1_A0_92_91_90_82_81_80);
        chk("f2_last_centre", {64'h0, last_centre}, 72'hC6);
        chk("b2b_err", {71'h0, line_err}, 72'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
